// File: rtl/noaa_pkg.sv
// Shared widths, defaults and state encoding for the NOAA sample scheduler.
// Optional ADC timeout is enabled with NOAA_SCHED_TIMEOUT_EN.
package noaa_pkg;

  localparam int unsigned TEMP_WIDTH      = 12;
  localparam int unsigned PERIOD_W        = 16;
  localparam int unsigned ITERS_DEF       = 4;
  localparam int unsigned DP_LAT          = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_REQ,
    S_AVG_PH,
    S_SD_PH,
    S_PUBLISH
  } sched_state_e;

  // A period of 0 behaves like 1: the tick fires on the first timer cycle.
  function automatic logic [PERIOD_W-1:0] reload_val(input logic [PERIOD_W-1:0] period);
    return (period == '0) ? '0 : period - 1'b1;
  endfunction

endpackage

// File: rtl/noaa_sample_sched_if.sv
// Control, ADC handshake and datapath signals of the sample scheduler.
interface noaa_sample_sched_if;

  logic                                start;
  logic [noaa_pkg::PERIOD_W-1:0]       period;
  logic                                adc_req;
  logic                                adc_ack;
  logic [noaa_pkg::TEMP_WIDTH-1:0]     adc_data;
  logic [noaa_pkg::TEMP_WIDTH-1:0]     tn;
  logic                                smpl_stb;
  logic                                mode;
  logic [noaa_pkg::TEMP_WIDTH-1:0]     dp_avg_sd;
  logic [noaa_pkg::TEMP_WIDTH-1:0]     avg;
  logic [noaa_pkg::TEMP_WIDTH-1:0]     sd;
  logic                                res_valid;
  logic                                busy;
  logic                                err;

  modport master (
    output start, period, adc_ack, adc_data, dp_avg_sd,
    input  adc_req, tn, smpl_stb, mode, avg, sd, res_valid, busy, err
  );

  modport slave (
    input  start, period, adc_ack, adc_data, dp_avg_sd,
    output adc_req, tn, smpl_stb, mode, avg, sd, res_valid, busy, err
  );

endinterface

// File: rtl/sched_tick_timer.sv
// Loadable down-counter pacing acquisitions; tick is high while the count is zero.
module sched_tick_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             en,
  input  logic [Width-1:0] load_val,
  output logic             tick
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/noaa_sample_sched.sv
// Acquisition sequencer: paced ADC fetch, mean phase, std-dev phase, publish.
// Define NOAA_SCHED_TIMEOUT_EN to abandon an unanswered ADC request and flag err.
module noaa_sample_sched
  import noaa_pkg::*;
#(
  parameter int unsigned ITERS       = ITERS_DEF,
  parameter int unsigned DP_LAT      = noaa_pkg::DP_LAT,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                clk,
  input logic                rst_n,
  noaa_sample_sched_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(ITERS + DP_LAT);
  localparam logic [CntW-1:0] AvgLast = CntW'(DP_LAT - 1);
  localparam logic [CntW-1:0] SdLast  = CntW'(ITERS + DP_LAT - 2);

  sched_state_e          state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  reload, tick, capture, timeout;
  logic [PERIOD_W-1:0]   load_val;
  logic                  adc_req_q, smpl_stb_q, mode_q, busy_q, res_valid_q;
  logic [TEMP_WIDTH-1:0] tn_q, avg_hold_q, sd_hold_q, avg_q, sd_q;

  assign load_val = reload_val(bus.period);
  // adc_req_q gates the capture so an ACK held past the handshake is ignored.
  assign capture  = (state_q == S_REQ) && adc_req_q && bus.adc_ack;

  sched_tick_timer #(
    .Width(PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .reload  (reload),
    .en      (state_q == S_WAIT_TICK),
    .load_val(load_val),
    .tick    (tick)
  );

`ifdef NOAA_SCHED_TIMEOUT_EN
  localparam int unsigned     ToW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ToW-1:0]  ToLast = ToW'(TIMEOUT_CYC - 1);

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;

  assign timeout = (state_q == S_REQ) && !bus.adc_ack && (to_cnt_q == ToLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == S_REQ) ? to_cnt_q + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reload  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_WAIT_TICK;
          reload  = 1'b1;
        end
      end
      S_WAIT_TICK: begin
        if (!bus.start)  state_d = S_IDLE;
        else if (tick)   state_d = S_REQ;
      end
      S_REQ: begin
        if (capture || timeout) begin
          state_d = S_AVG_PH;
          cnt_d   = '0;
        end
      end
      S_AVG_PH: begin
        if (cnt_q == AvgLast) begin
          state_d = S_SD_PH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SD_PH: begin
        if (cnt_q == SdLast) state_d = S_PUBLISH;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      S_PUBLISH: begin
        // The timer restarts here, so a long sequence only delays the next tick.
        if (bus.start) begin
          state_d = S_WAIT_TICK;
          reload  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      adc_req_q   <= 1'b0;
      smpl_stb_q  <= 1'b0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      tn_q        <= '0;
      avg_hold_q  <= '0;
      sd_hold_q   <= '0;
      avg_q       <= '0;
      sd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adc_req_q   <= (state_d == S_REQ);
      mode_q      <= (state_d == S_SD_PH);
      busy_q      <= !(state_d inside {S_IDLE, S_WAIT_TICK});
      smpl_stb_q  <= capture;
      res_valid_q <= (state_q == S_PUBLISH);
      if (capture) tn_q <= bus.adc_data;
      if ((state_q == S_AVG_PH) && (cnt_q == AvgLast)) avg_hold_q <= bus.dp_avg_sd;
      if ((state_q == S_SD_PH) && (cnt_q == SdLast))   sd_hold_q  <= bus.dp_avg_sd;
      if (state_q == S_PUBLISH) begin
        avg_q <= avg_hold_q;
        sd_q  <= sd_hold_q;
      end
    end
  end

  assign bus.adc_req   = adc_req_q;
  assign bus.smpl_stb  = smpl_stb_q;
  assign bus.mode      = mode_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.tn        = tn_q;
  assign bus.avg       = avg_q;
  assign bus.sd        = sd_q;

endmodule
